// File: rtl/matmul_systolic_core_if.sv
// rtl/matmul_systolic_core_if.sv - request/operand/result bundle for matmul_systolic_core
//
// Purpose: groups the start/busy request handshake, the operand buses and the
// valid/ready result handshake of the systolic matmul core into one interface.
// Ports (signals):
//   start, accum            request and accumulate-mode select (sampled together)
//   dim_n, dim_k, dim_m     matrix sizes minus one
//   matrix_a, matrix_b      operand matrices, one BUS_WIDTH word per row
//   busy                    core is processing a request
//   result_valid            result/flags hold a finished product
//   result_ready            consumer takes the result
//   result, flags           packed C matrix and per-element overflow flags
// Modports: master drives requests and consumes results; slave is the core.
interface matmul_systolic_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  logic                                 start;
  logic                                 accum;
  logic [DIM_W-1:0]                     dim_n;
  logic [DIM_W-1:0]                     dim_k;
  logic [DIM_W-1:0]                     dim_m;
  logic [MAX_DIM*BUS_WIDTH-1:0]         matrix_a;
  logic [MAX_DIM*BUS_WIDTH-1:0]         matrix_b;
  logic                                 busy;
  logic                                 result_valid;
  logic                                 result_ready;
  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] result;
  logic [MAX_DIM*MAX_DIM-1:0]           flags;

  modport master (
    output start, accum, dim_n, dim_k, dim_m, matrix_a, matrix_b, result_ready,
    input  busy, result_valid, result, flags
  );

  modport slave (
    input  start, accum, dim_n, dim_k, dim_m, matrix_a, matrix_b, result_ready,
    output busy, result_valid, result, flags
  );
endinterface

// File: rtl/matmul_systolic_core.sv
// rtl/matmul_systolic_core.sv - output-stationary systolic matrix multiplier core
//
// Purpose: computes C = A*B or C += A*B for runtime sizes N x K x M (1..MAX_DIM
// each) on a MAX_DIM x MAX_DIM array of MAC cells. Operands are captured when a
// request is accepted; A enters skewed from the west edge, B from the north edge.
// Each cell keeps its own accumulator and a sticky overflow flag.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   matmul_systolic_core_if.slave (request, operands, result handshake)
// Parameters: DATA_WIDTH element width, BUS_WIDTH word/accumulator width,
//   SIGNED_OP two's-complement arithmetic, SATURATE clamp instead of wrap.
module matmul_systolic_core #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter bit SIGNED_OP  = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  matmul_systolic_core_if.slave bus
);
  localparam int DW      = DATA_WIDTH;
  localparam int BW      = BUS_WIDTH;
  localparam int MAX_DIM = BW / DW;
  localparam int DIM_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  // feed counter reaches at most 3*MAX_DIM-3
  localparam int T_W     = $clog2(3 * MAX_DIM);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] FEED   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]                     state;
  logic [DIM_W-1:0]               n_lat;
  logic [DIM_W-1:0]               k_lat;
  logic [DIM_W-1:0]               m_lat;
  logic                           accum_lat;
  logic [MAX_DIM*BW-1:0]          a_lat;
  logic [MAX_DIM*BW-1:0]          b_lat;
  logic [T_W-1:0]                 t;
  logic [T_W-1:0]                 last_t;
  logic                           busy_q;
  logic                           valid_q;
  logic [BW*MAX_DIM*MAX_DIM-1:0]  result_q;
  logic [BW*MAX_DIM*MAX_DIM-1:0]  pack_res;
  logic [MAX_DIM*MAX_DIM-1:0]     flags_q;
  logic [MAX_DIM*MAX_DIM-1:0]     pack_flags;

  logic [DW-1:0] a_edge [MAX_DIM];
  logic [DW-1:0] b_edge [MAX_DIM];
  logic [DW-1:0] pe_a   [MAX_DIM][MAX_DIM];
  logic [DW-1:0] pe_b   [MAX_DIM][MAX_DIM];
  logic [BW-1:0] pe_acc [MAX_DIM][MAX_DIM];
  logic          pe_ovf [MAX_DIM][MAX_DIM];

  // last feed step is N+M+K-3, i.e. the sum of the minus-one dims
  assign last_t = T_W'(n_lat) + T_W'(k_lat) + T_W'(m_lat);

  // Skewed edge injection: row i lags by i cycles, column j by j cycles.
  // Rows/columns outside the active region stay zero so idle cells add nothing.
  always_comb begin
    for (int i = 0; i < MAX_DIM; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
    end
    if (state == FEED) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        if (i <= int'(n_lat) && int'(t) >= i && (int'(t) - i) <= int'(k_lat))
          a_edge[i] = a_lat[i*BW + (int'(t) - i)*DW +: DW];
      end
      for (int j = 0; j < MAX_DIM; j++) begin
        if (j <= int'(m_lat) && int'(t) >= j && (int'(t) - j) <= int'(k_lat))
          b_edge[j] = b_lat[(int'(t) - j)*BW + j*DW +: DW];
      end
    end
  end

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_pe
      logic [DW-1:0]   a_in;
      logic [DW-1:0]   b_in;
      logic [DW-1:0]   a_q;
      logic [DW-1:0]   b_q;
      logic [BW-1:0]   acc_q;
      logic [BW-1:0]   acc_d;
      logic            ovf_q;
      logic            ovf_add;
      logic [2*DW-1:0] a_x;
      logic [2*DW-1:0] b_x;
      logic [2*DW-1:0] prod;
      logic [BW-1:0]   prod_x;
      logic [BW:0]     sum;
      logic [BW-1:0]   sat_val;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_edge[gi];
      end else begin : g_a_hop
        assign a_in = pe_a[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = b_edge[gj];
      end else begin : g_b_hop
        assign b_in = pe_b[gi-1][gj];
      end

      assign pe_a[gi][gj]   = a_q;
      assign pe_b[gi][gj]   = b_q;
      assign pe_acc[gi][gj] = acc_q;
      assign pe_ovf[gi][gj] = ovf_q;

      always_comb begin
        // operands widened first so one multiplier serves both signednesses
        if (SIGNED_OP) begin
          a_x    = {{DW{a_in[DW-1]}}, a_in};
          b_x    = {{DW{b_in[DW-1]}}, b_in};
        end else begin
          a_x    = {{DW{1'b0}}, a_in};
          b_x    = {{DW{1'b0}}, b_in};
        end
        prod = a_x * b_x;
        if (SIGNED_OP) prod_x = BW'($signed(prod));
        else           prod_x = BW'(prod);
        sum = {1'b0, acc_q} + {1'b0, prod_x};
        if (SIGNED_OP) begin
          ovf_add = (acc_q[BW-1] == prod_x[BW-1]) && (sum[BW-1] != acc_q[BW-1]);
          sat_val = acc_q[BW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end else begin
          ovf_add = sum[BW];
          sat_val = '1;
        end
        acc_d = sum[BW-1:0];
        // once clamped the cell holds its limit until the next clearing start
        if (SATURATE) begin
          if (ovf_q)        acc_d = acc_q;
          else if (ovf_add) acc_d = sat_val;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else if (state == LOAD) begin
          a_q <= '0;
          b_q <= '0;
          if (!accum_lat) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end else if (state == FEED) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= acc_d;
          ovf_q <= ovf_q | ovf_add;
        end
      end
    end
  end

  // Row stride of the packed result follows the runtime M, not MAX_DIM.
  always_comb begin
    pack_res   = '0;
    pack_flags = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        if (i <= int'(n_lat) && j <= int'(m_lat)) begin
          pack_res[(i*(int'(m_lat) + 1) + j)*BW +: BW] = pe_acc[i][j];
          pack_flags[i*(int'(m_lat) + 1) + j]          = pe_ovf[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n_lat     <= '0;
      k_lat     <= '0;
      m_lat     <= '0;
      accum_lat <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      t         <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat     <= bus.dim_n;
            k_lat     <= bus.dim_k;
            m_lat     <= bus.dim_m;
            accum_lat <= bus.accum;
            a_lat     <= bus.matrix_a;
            b_lat     <= bus.matrix_b;
            busy_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          t     <= '0;
          state <= FEED;
        end
        FEED: begin
          t <= t + T_W'(1);
          if (t == last_t) state <= SETTLE;
        end
        SETTLE: begin
          result_q <= pack_res;
          flags_q  <= pack_flags;
          valid_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // a start seen here is deliberately dropped; IDLE sees it next cycle
          if (bus.result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.flags        = flags_q;
endmodule

// File: tb/tb_matmul_systolic_core.sv
// tb/tb_matmul_systolic_core.sv - bench for matmul_systolic_core
module tb_matmul_systolic_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  matmul_systolic_core_if #(.DATA_WIDTH(8), .BUS_WIDTH(32)) bus ();
  matmul_systolic_core_if #(.DATA_WIDTH(8), .BUS_WIDTH(16)) bus_s ();
  matmul_systolic_core_if #(.DATA_WIDTH(8), .BUS_WIDTH(16)) bus_w ();

  matmul_systolic_core #(.DATA_WIDTH(8), .BUS_WIDTH(32), .SIGNED_OP(1'b1), .SATURATE(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  matmul_systolic_core #(.DATA_WIDTH(8), .BUS_WIDTH(16), .SIGNED_OP(1'b1), .SATURATE(1'b1))
    dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
  matmul_systolic_core #(.DATA_WIDTH(8), .BUS_WIDTH(16), .SIGNED_OP(1'b1), .SATURATE(1'b0))
    dut_wrap (.clk(clk), .rst(rst), .bus(bus_w));

  typedef struct {
    logic [511:0] res;
    logic [15:0]  flags;
    longint       start_cyc;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t last;

  longint mdl_acc [4][4];
  bit     mdl_ovf [4][4];
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mdl_acc[i][j] = 0;
        mdl_ovf[i][j] = 1'b0;
      end
  endtask

  // drives operands and computes the expected result into cur
  task automatic drive_ops(input int n, input int k, input int m, input bit acc,
                           input logic [127:0] a, input logic [127:0] b, input string tag);
    logic signed [7:0] av;
    logic signed [7:0] bv;
    longint v;
    int idx;
    bus.dim_n    = 2'(n);
    bus.dim_k    = 2'(k);
    bus.dim_m    = 2'(m);
    bus.accum    = acc;
    bus.matrix_a = a;
    bus.matrix_b = b;
    if (!acc) model_clear();
    for (int i = 0; i <= n; i++)
      for (int j = 0; j <= m; j++)
        for (int kk = 0; kk <= k; kk++)
          if (!mdl_ovf[i][j]) begin
            av = a[i*32 + kk*8 +: 8];
            bv = b[kk*32 + j*8 +: 8];
            v = mdl_acc[i][j] + longint'(av) * longint'(bv);
            if (v > MAXV) begin v = MAXV; mdl_ovf[i][j] = 1'b1; end
            else if (v < MINV) begin v = MINV; mdl_ovf[i][j] = 1'b1; end
            mdl_acc[i][j] = v;
          end
    cur.res   = '0;
    cur.flags = '0;
    for (int i = 0; i <= n; i++)
      for (int j = 0; j <= m; j++) begin
        idx = i*(m + 1) + j;
        cur.res[idx*32 +: 32] = 32'(mdl_acc[i][j]);
        cur.flags[idx]        = mdl_ovf[i][j];
      end
    cur.lat = n + k + m + 3;
    cur.tag = tag;
  endtask

  task automatic start_op(input int n, input int k, input int m, input bit acc,
                          input logic [127:0] a, input logic [127:0] b, input string tag);
    @(negedge clk);
    drive_ops(n, k, m, acc, a, b, tag);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    cur.start_cyc = cyc;
    sb.push_back(cur);
    check({tag, "_busy"}, 512'(bus.busy), 512'(1));
  endtask

  task automatic wait_result();
    exp_t e;
    int guard = 0;
    while (bus.result_valid !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("sb_nonempty", 512'(sb.size() > 0), 512'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    last = e;
    check({e.tag, "_valid"}, 512'(bus.result_valid), 512'(1));
    check({e.tag, "_latency"}, 512'(cyc - e.start_cyc), 512'(e.lat));
    check({e.tag, "_result"}, bus.result, e.res);
    check({e.tag, "_flags"}, 512'(bus.flags), 512'(e.flags));
  endtask

  task automatic ack();
    @(posedge clk);
    #1;
    check({last.tag, "_hold_valid"}, 512'(bus.result_valid), 512'(1));
    check({last.tag, "_hold_result"}, bus.result, last.res);
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check({last.tag, "_ack_valid"}, 512'(bus.result_valid), 512'(0));
    check({last.tag, "_ack_busy"}, 512'(bus.busy), 512'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] a1, b1, a3, b3, ra, rb;
    int rn, rk, rm, seen, guard;
    bit racc;

    a1 = {64'h0, 32'h0000_0403, 32'h0000_0201};
    b1 = {64'h0, 32'h0000_0100, 32'h0000_0001};
    a3 = {64'h0, 32'h0006_0504, 32'h0003_0201};
    b3 = {32'h0, 32'h0101_0000, 32'h0100_0100, 32'h0100_0001};

    bus.start = 0; bus.accum = 0; bus.dim_n = 0; bus.dim_k = 0; bus.dim_m = 0;
    bus.matrix_a = '0; bus.matrix_b = '0; bus.result_ready = 0;
    bus_s.start = 0; bus_s.accum = 0; bus_s.dim_n = 0; bus_s.dim_k = 0; bus_s.dim_m = 0;
    bus_s.matrix_a = '0; bus_s.matrix_b = '0; bus_s.result_ready = 0;
    bus_w.start = 0; bus_w.accum = 0; bus_w.dim_n = 0; bus_w.dim_k = 0; bus_w.dim_m = 0;
    bus_w.matrix_a = '0; bus_w.matrix_b = '0; bus_w.result_ready = 0;
    model_clear();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 512'(bus.busy), 512'(0));
    check("rst_valid", 512'(bus.result_valid), 512'(0));
    check("rst_result", bus.result, 512'(0));
    check("rst_flags", 512'(bus.flags), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // 2x2x2 identity
    start_op(1, 1, 1, 1'b0, a1, b1, "t1");
    wait_result();
    check("t1_words", 512'(bus.result[127:0]), 512'({32'd4, 32'd3, 32'd2, 32'd1}));
    ack();

    // 4x4x4 signed extremes
    start_op(3, 3, 3, 1'b0, {16{8'h80}}, {16{8'h7F}}, "t2");
    wait_result();
    check("t2_words", bus.result, {16{32'hFFFF_0200}});
    ack();

    // non-square 2x3x4
    start_op(1, 2, 3, 1'b0, a3, b3, "t3");
    wait_result();
    check("t3_words", bus.result,
          512'({32'd15, 32'd6, 32'd5, 32'd4, 32'd6, 32'd3, 32'd2, 32'd1}));
    ack();

    // accumulate on top of the previous result
    start_op(1, 2, 3, 1'b1, a3, b3, "t5_accum");
    wait_result();
    check("t5_words", bus.result,
          512'({32'd30, 32'd12, 32'd10, 32'd8, 32'd12, 32'd6, 32'd4, 32'd2}));
    ack();

    // 1x1x1, minimum latency
    start_op(0, 0, 0, 1'b0, {120'h0, 8'd5}, {120'h0, 8'hFD}, "t_1x1");
    wait_result();
    check("t_1x1_word", bus.result, 512'(32'hFFFF_FFF1));
    ack();

    for (int r = 0; r < 4; r++) begin
      rn = $urandom_range(0, 3); rk = $urandom_range(0, 3); rm = $urandom_range(0, 3);
      racc = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      start_op(rn, rk, rm, racc, ra, rb, $sformatf("rand%0d", r));
      wait_result();
      ack();
    end

    // reset in the middle of FEED
    start_op(3, 3, 3, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {16{8'h11}}, "t_abort");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 512'(bus.busy), 512'(0));
    check("abort_valid", 512'(bus.result_valid), 512'(0));
    check("abort_result", bus.result, 512'(0));
    sb.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.result_valid) seen = 1;
    end
    check("abort_no_valid", 512'(seen), 512'(0));

    // accumulate right after reset works on zeroed accumulators
    start_op(1, 2, 3, 1'b1, a3, b3, "t_accum_rst");
    wait_result();
    check("t_accum_rst_words", bus.result,
          512'({32'd15, 32'd6, 32'd5, 32'd4, 32'd6, 32'd3, 32'd2, 32'd1}));
    ack();

    // start pulses and operand changes while busy are ignored
    start_op(3, 3, 3, 1'b0, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, "t_busy_ign");
    repeat (3) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.accum    = 1'b1;
      bus.matrix_a = ~bus.matrix_a;
      bus.matrix_b = ~bus.matrix_b;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_result();
    ack();

    // start and ready in the same DONE cycle
    start_op(0, 1, 1, 1'b0, a1, b1, "t_pre");
    wait_result();
    @(negedge clk);
    drive_ops(1, 1, 1, 1'b0, a1, b1, "t_same_cycle");
    bus.start        = 1'b1;
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    check("same_cycle_valid", 512'(bus.result_valid), 512'(0));
    check("same_cycle_busy", 512'(bus.busy), 512'(0));
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    cur.start_cyc = cyc;
    sb.push_back(cur);
    check("same_cycle_accept", 512'(bus.busy), 512'(1));
    wait_result();
    ack();

    // 16-bit accumulator: (-128*-128)*2 overflows, saturating vs wrapping
    @(negedge clk);
    bus_s.dim_n = 1; bus_s.dim_k = 1; bus_s.dim_m = 1;
    bus_s.matrix_a = 32'h8080_8080; bus_s.matrix_b = 32'h8080_8080;
    bus_w.dim_n = 1; bus_w.dim_k = 1; bus_w.dim_m = 1;
    bus_w.matrix_a = 32'h8080_8080; bus_w.matrix_b = 32'h8080_8080;
    bus_s.start = 1'b1;
    bus_w.start = 1'b1;
    @(posedge clk);
    #1;
    bus_s.start = 1'b0;
    bus_w.start = 1'b0;
    guard = 0;
    while ((bus_s.result_valid !== 1'b1 || bus_w.result_valid !== 1'b1) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("sat16_valid", 512'(bus_s.result_valid), 512'(1));
    check("sat16_latency", 512'(guard), 512'(6));
    check("sat16_result", 512'(bus_s.result), 512'({4{16'h7FFF}}));
    check("sat16_flags", 512'(bus_s.flags), 512'(4'hF));
    check("wrap16_valid", 512'(bus_w.result_valid), 512'(1));
    check("wrap16_result", 512'(bus_w.result), 512'({4{16'h8000}}));
    check("wrap16_flags", 512'(bus_w.flags), 512'(4'hF));
    @(negedge clk);
    bus_s.result_ready = 1'b1;
    bus_w.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_s.result_ready = 1'b0;
    bus_w.result_ready = 1'b0;
    check("sat16_ack_busy", 512'(bus_s.busy), 512'(0));
    check("wrap16_ack_valid", 512'(bus_w.result_valid), 512'(0));

    check("sb_drained", 512'(sb.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
